// File: rtl/axi_address_decoder_ar_ordered.sv
// AR-channel address decoder for one master port: range decode with fixed priority,
// in-order target stalling on outstanding reads, and an error-responder handoff.
module axi_address_decoder_ar_ordered #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned N_INIT_PORT     = 8,
  parameter int unsigned N_REGION        = 4,
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter bit          DEFAULT_EN      = 1'b0,
  parameter int unsigned DEFAULT_PORT    = 0,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       arvalid_i,
  input  logic [ADDR_WIDTH-1:0]                      araddr_i,
  input  logic [ID_WIDTH-1:0]                        arid_i,
  input  logic [7:0]                                 arlen_i,
  output logic                                       arready_o,
  output logic [N_INIT_PORT-1:0]                     arvalid_o,
  input  logic [N_INIT_PORT-1:0]                     arready_i,
  input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] START_ADDR_i,
  input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] END_ADDR_i,
  input  logic [N_REGION*N_INIT_PORT-1:0]            enable_region_i,
  input  logic [N_INIT_PORT-1:0]                     connectivity_map_i,
  input  logic                                       rburst_done_i,
  output logic [CNT_W-1:0]                           outstanding_o,
  output logic                                       error_req_o,
  output logic [ID_WIDTH-1:0]                        error_id_o,
  output logic [7:0]                                 error_len_o,
  input  logic                                       error_gnt_i,
  output logic                                       sample_ardata_info_o
);

  localparam int unsigned TGT_W = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;

  localparam logic [0:0] OPERATIVE = 1'b0;
  localparam logic [0:0] ERR_REQ   = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TGT_W-1:0]       last_tgt_q, last_tgt_d;
  logic [ID_WIDTH-1:0]    error_id_q, error_id_d;
  logic [7:0]             error_len_q, error_len_d;

  logic [N_INIT_PORT-1:0] match;
  logic                   route_ok;
  logic [TGT_W-1:0]       tgt;
  logic                   stall;
  logic                   cnt_inc;
  logic                   cnt_dec;

  // Region match per init port, masked by connectivity
  always_comb begin
    match = '0;
    for (int i = 0; i < int'(N_INIT_PORT); i++) begin
      for (int j = 0; j < int'(N_REGION); j++) begin
        if (enable_region_i[j*N_INIT_PORT + i] &&
            (START_ADDR_i[(j*N_INIT_PORT + i)*ADDR_WIDTH +: ADDR_WIDTH] <= araddr_i) &&
            (araddr_i <= END_ADDR_i[(j*N_INIT_PORT + i)*ADDR_WIDTH +: ADDR_WIDTH])) begin
          match[i] = 1'b1;
        end
      end
    end
    match = match & connectivity_map_i;
  end

  // Lowest matching port wins; unmatched falls back to the default port when allowed
  always_comb begin
    route_ok = 1'b0;
    tgt      = '0;
    for (int i = int'(N_INIT_PORT) - 1; i >= 0; i--) begin
      if (match[i]) begin
        route_ok = 1'b1;
        tgt      = TGT_W'(i);
      end
    end
    if (!route_ok && DEFAULT_EN && connectivity_map_i[DEFAULT_PORT]) begin
      route_ok = 1'b1;
      tgt      = TGT_W'(DEFAULT_PORT);
    end
  end

  // A new target must wait until every earlier burst has returned
  assign stall = (cnt_q == CNT_W'(MAX_OUTSTANDING)) ||
                 ((cnt_q != '0) && (tgt != last_tgt_q));

  always_comb begin
    state_d              = state_q;
    last_tgt_d           = last_tgt_q;
    error_id_d           = error_id_q;
    error_len_d          = error_len_q;
    cnt_inc              = 1'b0;
    arvalid_o            = '0;
    arready_o            = 1'b0;
    sample_ardata_info_o = 1'b0;

    case (state_q)
      OPERATIVE: begin
        if (arvalid_i) begin
          if (route_ok) begin
            if (!stall) begin
              arvalid_o[tgt] = 1'b1;
              arready_o      = arready_i[tgt];
              if (arready_i[tgt]) begin
                cnt_inc    = 1'b1;
                last_tgt_d = tgt;
              end
            end
          end else if (cnt_q == '0) begin
            arready_o            = 1'b1;
            sample_ardata_info_o = 1'b1;
            error_id_d           = arid_i;
            error_len_d          = arlen_i;
            state_d              = ERR_REQ;
          end
        end
      end
      ERR_REQ: begin
        if (error_gnt_i) begin
          cnt_inc = 1'b1;
          state_d = OPERATIVE;
        end
      end
      default: state_d = OPERATIVE;
    endcase
  end

  // Returns at an empty counter are dropped rather than wrapping
  assign cnt_dec = rburst_done_i && (cnt_q != '0);
  assign cnt_d   = cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= OPERATIVE;
      cnt_q       <= '0;
      last_tgt_q  <= '0;
      error_id_q  <= '0;
      error_len_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_tgt_q  <= last_tgt_d;
      error_id_q  <= error_id_d;
      error_len_q <= error_len_d;
    end
  end

  assign outstanding_o = cnt_q;
  assign error_req_o   = (state_q == ERR_REQ);
  assign error_id_o    = error_id_q;
  assign error_len_o   = error_len_q;

  a_done_with_pending: assert property (@(posedge clk) disable iff (!rst_n)
    rburst_done_i |-> (cnt_q != '0));

endmodule
